// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single combinational full-adder cell used by the serial adder datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell processes a+b+cin LSB first, one bit per clock.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_sum, fa_cout;

    full_adder u_full_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                work_d  = {fa_sum, work_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_sum, work_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_assert;
    int n_fail;
    logic [8:0] last_res;

    serial_adder_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One addition from an IDLE start; full=1 adds timing/hold checks,
    // mangle=1 disturbs inputs and pulses start during RUN and DONE.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [8:0] exp, input bit full, input bit mangle);
        int k;
        int bcnt;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        cin   = tc;
        tick();
        start = 1'b0;
        k     = 0;
        bcnt  = 0;
        while (!done && k < 20) begin
            if (busy) bcnt++;
            if (full && k == 4) chk("hold_during_run", 32'({cout, sum}), 32'(last_res));
            if (mangle && k == 3) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                cin   = 1'($urandom);
                start = 1'b1;
            end
            if (mangle && k == 4) start = 1'b0;
            tick();
            k++;
        end
        if (full) begin
            chk("latency", 32'(k), 32'(8));
            chk("busy_cycles", 32'(bcnt), 32'(8));
            chk("busy_at_done", 32'(busy), 32'(0));
        end
        chk("result", 32'({cout, sum}), 32'(exp));
        last_res = exp;
        if (mangle) start = 1'b1;
        tick();
        start = 1'b0;
        if (full) chk("done_one_cycle", 32'(done), 32'(0));
        if (mangle) begin
            tick();
            chk("no_accept_in_done", 32'(busy), 32'(0));
        end
    endtask

    initial begin
        int ndone;
        int prev_t;
        logic [7:0] av;
        logic [7:0] bv;
        logic [8:0] ref_v;

        n_assert = 0;
        n_fail   = 0;
        last_res = '0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        rst_n    = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_no_start", 32'(busy), 32'(0));

        run_op(8'h00, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1, 1'b0);
        run_op(8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b1, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 1'b1, 9'h101, 1'b1, 1'b0);

        // Back-to-back with start held high.
        start  = 1'b1;
        a      = 8'h12;
        b      = 8'h34;
        cin    = 1'b1;
        ndone  = 0;
        prev_t = -1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (done) begin
                ndone++;
                if (prev_t >= 0) chk("b2b_period", 32'(e - prev_t), 32'(10));
                chk("b2b_result", 32'({cout, sum}), 32'(9'h047));
                prev_t = e;
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'(3));
        tick();
        tick();
        chk("b2b_idle", 32'(busy), 32'(0));
        last_res = 9'h047;

        // Input changes and start pulses during RUN/DONE are ignored.
        run_op(8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b1, 1'b1);

        // Reset on the 4th RUN cycle aborts with no done pulse.
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
        cin   = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_sum", 32'(sum), 32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        ndone = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'(0));
        last_res = '0;
        run_op(8'hC8, 8'h64, 1'b1, 9'h12D, 1'b1, 1'b0);

        // Sparse sweep of a, b, cin against a reference sum.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    av    = 8'(ai * 17);
                    bv    = 8'(bi * 17 + 3);
                    ref_v = 9'(av) + 9'(bv) + 9'(ci);
                    run_op(av, bv, 1'(ci), ref_v, 1'b0, 1'b0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
